// File: rtl/prime_candidate_gen_pkg.sv
// Shared types and helpers for the prime candidate search controller.
package prime_gen_pkg;

    // Explicit encodings keep the state values identical to the legacy netlist.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GATHER = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HOLD   = 3'd4,
        ST_FAIL   = 3'd5
    } state_e;

    function automatic int unsigned nwords(input int unsigned wordsize, input int unsigned rand_w);
        return (wordsize + rand_w - 1) / rand_w;
    endfunction

    function automatic int unsigned cnt_inc_sat(input int unsigned cnt, input int unsigned max_cnt);
        return (cnt >= max_cnt) ? max_cnt : cnt + 1;
    endfunction

    function automatic logic cnt_is_last(input int unsigned cnt, input int unsigned max_cnt);
        return (cnt + 1) == max_cnt;
    endfunction

endpackage

// File: rtl/prime_candidate_gen_assembler.sv
// Packs consecutive random words into an odd WORDSIZE-bit candidate.
module candidate_assembler
    import prime_gen_pkg::*;
#(
    parameter int unsigned WORDSIZE  = 31,
    parameter int unsigned RAND_W    = 16,
    parameter bit          FORCE_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [RAND_W-1:0]   rand_in,
    output logic                done,
    output logic [WORDSIZE-1:0] candidate
);

    localparam int unsigned NWORDS = nwords(WORDSIZE, RAND_W);
    localparam int unsigned WIDE_W = NWORDS * RAND_W;
    localparam int unsigned KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

    logic [KW-1:0]       k_q, k_d;
    logic [WORDSIZE-1:0] cand_q, cand_d;
    logic [WIDE_W-1:0]   wide;

    // Words land in a word-aligned scratch vector; bits above WORDSIZE fall off on truncation.
    always_comb begin
        k_d    = k_q;
        cand_d = cand_q;
        wide   = '0;
        wide[WORDSIZE-1:0] = cand_q;
        done   = load && (k_q == K_LAST);
        if (load) begin
            wide[32'(k_q) * RAND_W +: RAND_W] = rand_in;
            cand_d = wide[WORDSIZE-1:0];
            if (done) begin
                cand_d[0] = 1'b1;
                if (FORCE_MSB) begin
                    cand_d[WORDSIZE-1] = 1'b1;
                end
                k_d = '0;
            end else begin
                k_d = k_q + KW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q    <= '0;
            cand_q <= '0;
        end else begin
            k_q    <= k_d;
            cand_q <= cand_d;
        end
    end

    assign candidate = cand_q;

endmodule

// File: rtl/prime_candidate_gen.sv
// Prime search controller: draws odd candidates, drives miller_rabin, returns a prime or times out.
module prime_candidate_gen
    import prime_gen_pkg::*;
#(
    parameter int unsigned WORDSIZE  = 31,
    parameter int unsigned RAND_W    = 16,
    parameter int unsigned MAX_TRIES = 64,
    parameter bit          FORCE_MSB = 1'b1,
    parameter int unsigned CNT_W     = $clog2(MAX_TRIES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [RAND_W-1:0]   rand_in,
    output logic                rand_en,
    output logic [WORDSIZE-1:0] mr_candidate,
    output logic                mr_reset,
    input  logic                mr_finish,
    input  logic                mr_prime,
    output logic [WORDSIZE-1:0] prime_out,
    output logic                prime_valid,
    input  logic                prime_ready,
    output logic                busy,
    output logic [CNT_W-1:0]    attempts,
    output logic                timeout
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    attempts_q, attempts_d;
    logic [WORDSIZE-1:0] prime_q, prime_d;
    logic                blank_q;
    logic                asm_done;

    candidate_assembler #(
        .WORDSIZE  (WORDSIZE),
        .RAND_W    (RAND_W),
        .FORCE_MSB (FORCE_MSB)
    ) u_asm (
        .clk       (clk),
        .reset     (reset),
        .load      (rand_en),
        .rand_in   (rand_in),
        .done      (asm_done),
        .candidate (mr_candidate)
    );

    always_comb begin
        state_d    = state_q;
        attempts_d = attempts_q;
        prime_d    = prime_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_GATHER;
                    attempts_d = '0;
                end
            end
            ST_GATHER: begin
                if (asm_done) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                // blank_q masks the finish flag left over from the previous run of the tester.
                if (!blank_q && mr_finish) begin
                    attempts_d = CNT_W'(cnt_inc_sat(32'(attempts_q), MAX_TRIES));
                    if (mr_prime) begin
                        prime_d = mr_candidate;
                        state_d = ST_HOLD;
                    end else if (cnt_is_last(32'(attempts_q), MAX_TRIES)) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_GATHER;
                    end
                end
            end
            ST_HOLD: begin
                if (prime_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            attempts_q <= '0;
            prime_q    <= '0;
            blank_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            attempts_q <= attempts_d;
            prime_q    <= prime_d;
            blank_q    <= (state_q == ST_LAUNCH);
        end
    end

    assign rand_en     = (state_q == ST_GATHER);
    assign mr_reset    = (state_q != ST_WAIT);
    assign busy        = (state_q != ST_IDLE);
    assign prime_valid = (state_q == ST_HOLD);
    assign timeout     = (state_q == ST_FAIL);
    assign prime_out   = prime_q;
    assign attempts    = attempts_q;

endmodule
